pll_lock_sequencer: RTL and testbench

- Sequences the fabric PLL from power-up and keeps it supervised while the system runs.
- Pulses the PLL reset, waits for lock with a timeout, and requires lock to stay continuously stable before releasing the downstream system reset.
- On loss of lock it re-resets the PLL and counts the event; if lock never arrives after a bounded number of retries it goes to a sticky failure state.
- Runs on the free-running 50 MHz board reference clock, upstream of every PLL-clocked domain.

---
 rtl/pll_seq_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 137 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer and its CSR read-back decoder.
package pll_seq_pkg;

  localparam int LOST_CNT_W = 8;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer, async active-low reset, resets to 0.
module sync_2ff (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and supervision: reset pulse, lock wait with timeout and retries,
// stability qualification, downstream reset release and lock-loss accounting.
//
// state     | meaning
// RESET_PLL | pll_rst asserted for RST_PULSE_CYCLES
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABILIZE | lock must hold for LOCK_STABLE_CYCLES consecutive cycles
// RUN       | downstream reset released, supervising lock
// FAILED    | retries exhausted, sticky until sw_restart or reset_n
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  locked_async,
  input  logic                  sw_restart,
  output logic                  pll_rst,
  output logic                  sys_reset_n,
  output logic                  lock_stable,
  output logic                  fail,
  output logic [LOST_CNT_W-1:0] lost_lock_count,
  output logic [2:0]            state_o
);

  localparam int unsigned RTRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRIES);

  logic                  locked_s;
  pll_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RTRY_W-1:0]     retry_q, retry_d;
  logic [LOST_CNT_W-1:0] lost_q, lost_d;

  sync_2ff u_lock_sync (
    .clk_sys (clk),
    .rst_b   (reset_n),
    .d       (locked_async),
    .q       (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (sw_restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // lock is checked first so it wins over a coincident timeout
          if (locked_s) begin
            state_d = STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_q + RTRY_W'(1);
            cnt_d   = '0;
            state_d = (retry_d == RTRY_MAX) ? FAILED : RESET_PLL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          retry_d = '0;
          if (!locked_s) begin
            if (lost_q != '1) lost_d = lost_q + LOST_CNT_W'(1);
            state_d = RESET_PLL;
            cnt_d   = '0;
          end
        end
        FAILED: ;
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they move on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      lock_stable <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_rst     <= (state_d == RESET_PLL);
      sys_reset_n <= (state_d == RUN);
      lock_stable <= (state_d == RUN);
      fail        <= (state_d == FAILED);
    end
  end

  assign state_o         = state_q;
  assign lost_lock_count = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: phase/elapsed-time reference model plus directed
// and randomized scenarios with hand-computed timing expectations.
module tb_pll_lock_sequencer;

  localparam int RST = 4;
  localparam int STB = 8;
  localparam int TO  = 32;
  localparam int MR  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       locked_async = 1'b0;
  logic       sw_restart = 1'b0;
  logic       pll_rst, sys_reset_n, lock_stable, fail;
  logic [7:0] lost_lock_count;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int rst_hi = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR),
    .CNT_W               (17)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .locked_async    (locked_async),
    .sw_restart      (sw_restart),
    .pll_rst         (pll_rst),
    .sys_reset_n     (sys_reset_n),
    .lock_stable     (lock_stable),
    .fail            (fail),
    .lost_lock_count (lost_lock_count),
    .state_o         (state_o)
  );

  always #10 clk = ~clk;

  // Reference model: phase number, cycles spent in the phase, attempts, losses,
  // and a two-deep delay line for the lock synchronizer.
  int m_phase, m_t, m_tries, m_lost;
  bit m_pipe0, m_pipe1, m_ls;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_t = 0; m_tries = 0; m_lost = 0;
      m_pipe0 = 0; m_pipe1 = 0;
    end else begin
      m_ls = m_pipe1;
      if (sw_restart) begin
        m_phase = 0; m_t = 0; m_tries = 0;
      end else if (m_phase == 0) begin
        m_t++;
        if (m_t == RST) begin m_phase = 1; m_t = 0; end
      end else if (m_phase == 1) begin
        if (m_ls) begin
          m_phase = 2; m_t = 0;
        end else begin
          m_t++;
          if (m_t == TO) begin
            m_tries++;
            m_t = 0;
            m_phase = (m_tries == MR) ? 4 : 0;
          end
        end
      end else if (m_phase == 2) begin
        if (!m_ls) begin
          m_phase = 1; m_t = 0;
        end else begin
          m_t++;
          if (m_t == STB) begin m_phase = 3; m_t = 0; end
        end
      end else if (m_phase == 3) begin
        m_tries = 0;
        if (!m_ls) begin
          m_lost = (m_lost < 255) ? m_lost + 1 : 255;
          m_phase = 0; m_t = 0;
        end
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = locked_async;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (state_o !== 3'(m_phase) || pll_rst !== (m_phase == 0) ||
          sys_reset_n !== (m_phase == 3) || lock_stable !== (m_phase == 3) ||
          fail !== (m_phase == 4) || lost_lock_count !== 8'(m_lost)) begin
        errors++;
        $display("FAIL model_cmp t=%0t state=%0d exp %0d pll_rst=%b sys_reset_n=%b lock_stable=%b fail=%b lost=%0d exp %0d",
                 $time, state_o, m_phase, pll_rst, sys_reset_n, lock_stable, fail,
                 lost_lock_count, m_lost);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n && pll_rst) rst_hi++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(state_o) != s && n < budget) begin
      tick(1);
      n++;
    end
    chk($sformatf("wait_state_%0d", s), int'(state_o), s);
  endtask

  task automatic pulse_restart();
    sw_restart = 1'b1;
    tick(1);
    sw_restart = 1'b0;
  endtask

  initial begin
    int n, base, pulses, bad;
    bit prev;

    #25;
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_sys_reset_n", int'(sys_reset_n), 0);
    chk("rst_state", int'(state_o), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_lost", int'(lost_lock_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // clean bring-up
    n = 0;
    while (pll_rst && n < 50) begin n++; tick(1); end
    chk("bringup_rst_width", n, 4);
    tick(10);
    locked_async = 1'b1;
    n = 0;
    while (!sys_reset_n && n < 100) begin tick(1); n++; end
    chk("bringup_sys_delay", n, 11);
    chk("bringup_lock_stable", int'(lock_stable), 1);
    chk("bringup_state", int'(state_o), 3);

    // glitch during STABILIZE
    pulse_restart();
    wait_state(2, 100);
    tick(5);
    base = rst_hi;
    locked_async = 1'b0;
    tick(3);
    chk("glitch_back_to_wait", int'(state_o), 1);
    locked_async = 1'b1;
    wait_state(2, 50);
    n = 0;
    while (state_o == 3'd2 && n < 50) begin tick(1); n++; end
    chk("glitch_full_stabilize", n, 8);
    chk("glitch_run", int'(state_o), 3);
    chk("glitch_no_pll_rst", rst_hi - base, 0);

    // three lock losses in RUN
    for (int i = 0; i < 3; i++) begin
      locked_async = 1'b0;
      n = 0;
      while (sys_reset_n && n < 20) begin tick(1); n++; end
      chk("loss_sys_delay", n, 3);
      n = 0;
      while (pll_rst && n < 20) begin tick(1); n++; end
      chk("loss_rst_width", n, 4);
      locked_async = 1'b1;
      wait_state(3, 100);
    end
    chk("loss_count3", int'(lost_lock_count), 3);

    // restart coinciding with a RUN lock loss
    locked_async = 1'b0;
    tick(2);
    pulse_restart();
    chk("coincide_state", int'(state_o), 0);
    chk("coincide_count", int'(lost_lock_count), 3);
    locked_async = 1'b1;
    wait_state(3, 100);

    // saturation
    for (int i = 0; i < 300; i++) begin
      locked_async = 1'b0;
      tick(4);
      locked_async = 1'b1;
      wait_state(3, 100);
    end
    chk("loss_saturate", int'(lost_lock_count), 255);

    // never lock
    locked_async = 1'b0;
    base = rst_hi;
    pulse_restart();
    n = 0; pulses = 0; prev = 1'b0;
    while (!fail && n < 500) begin
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
      n++;
      tick(1);
    end
    chk("nolock_cycles_to_fail", n, 72);
    chk("nolock_pulses", pulses, 2);
    chk("nolock_rst_cycles", rst_hi - base, 8);
    bad = 0;
    repeat (1000) begin
      if (!(fail && state_o == 3'd4 && !pll_rst && !sys_reset_n && !lock_stable)) bad++;
      tick(1);
    end
    chk("failed_hold_bad", bad, 0);
    chk("failed_state", int'(state_o), 4);

    // recovery from FAILED
    locked_async = 1'b1;
    pulse_restart();
    chk("recover_fail_low", int'(fail), 0);
    n = 0;
    while (pll_rst && n < 20) begin n++; tick(1); end
    chk("recover_rst_width", n, 4);
    wait_state(3, 100);
    chk("recover_lost_kept", int'(lost_lock_count), 255);

    // randomized lock activity and restarts
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) locked_async = ~locked_async;
      sw_restart = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    sw_restart = 1'b0;

    // async reset mid-STABILIZE
    locked_async = 1'b1;
    pulse_restart();
    wait_state(2, 100);
    tick(3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset_pll_rst", int'(pll_rst), 1);
    chk("areset_sys_reset_n", int'(sys_reset_n), 0);
    chk("areset_lock_stable", int'(lock_stable), 0);
    chk("areset_lost", int'(lost_lock_count), 0);
    chk("areset_state", int'(state_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
